decode_pipe: RTL

Parametrised decode stage: a multi-register file with same-cycle write-back bypass, a configurable immediate extender and jump-address pass-through, all captured into a registered ID/EX pipeline boundary with stall and flush control. It sits between instruction fetch/decode control and the execute stage of the datapath, and it is the pipelined successor of the combinational register-file/extender block.

---
 rtl/decode_pipe.sv | 131 +++++++++++++
 1 files changed

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - register file with write-back bypass, immediate extender and registered ID/EX boundary
module decode_pipe #(
  parameter int DATA_W  = 32,
  parameter int NREG    = 32,
  parameter int IMD_W   = 16,
  parameter int JADDR_W = 26,
  parameter int ZERO_R0 = 1,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic               reloj,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  DIR_A,
  input  logic [ADDR_W-1:0]  DIR_B,
  input  logic [ADDR_W-1:0]  DIR_WRA,
  input  logic [DATA_W-1:0]  DI,
  input  logic               REG_WR,
  input  logic               REG_RD,
  input  logic [1:0]         IMD_MODE,
  input  logic [IMD_W-1:0]   IMD,
  input  logic [JADDR_W-1:0] address,
  output logic [DATA_W-1:0]  DOA,
  output logic [DATA_W-1:0]  DOB,
  output logic [DATA_W-1:0]  out_mux_sz,
  output logic [JADDR_W-1:0] out_addr,
  output logic               out_valid
);

  logic [DATA_W-1:0]  registro_q [NREG];
  logic [DATA_W-1:0]  doa_q, doa_d;
  logic [DATA_W-1:0]  dob_q, dob_d;
  logic [DATA_W-1:0]  imm_q, imm_d;
  logic [JADDR_W-1:0] addr_q, addr_d;
  logic               valid_q, valid_d;

  logic               wr_en;
  logic [DATA_W-1:0]  rd_a, rd_b;
  logic [DATA_W-1:0]  imm_sext;
  logic [DATA_W-1:0]  imm_ext;

  // Index 0 is hardwired when ZERO_R0 is set, so it is neither writable nor bypassable.
  assign wr_en = !REG_WR && !((ZERO_R0 != 0) && (DIR_WRA == '0));

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] dir,
    input logic [DATA_W-1:0] arr_val
  );
    logic [DATA_W-1:0] v;
    v = arr_val;
    if (REG_RD) begin
      v = '0;
    end else if ((ZERO_R0 != 0) && (dir == '0)) begin
      v = '0;
    end else if (wr_en && (DIR_WRA == dir)) begin
      v = DI;
    end
    return v;
  endfunction

  assign rd_a = read_port(DIR_A, registro_q[DIR_A]);
  assign rd_b = read_port(DIR_B, registro_q[DIR_B]);

  assign imm_sext = {{(DATA_W-IMD_W){IMD[IMD_W-1]}}, IMD};

  always_comb begin
    imm_ext = '0;
    case (IMD_MODE)
      2'b00:   imm_ext = {{(DATA_W-IMD_W){1'b0}}, IMD};
      2'b01:   imm_ext = imm_sext;
      2'b10:   imm_ext = {IMD, {(DATA_W-IMD_W){1'b0}}};
      default: imm_ext = imm_sext << 2;
    endcase
  end

  always_comb begin
    doa_d   = doa_q;
    dob_d   = dob_q;
    imm_d   = imm_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    if (flush) begin
      doa_d   = '0;
      dob_d   = '0;
      imm_d   = '0;
      addr_d  = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      doa_d   = rd_a;
      dob_d   = rd_b;
      imm_d   = imm_ext;
      addr_d  = address;
      valid_d = in_valid;
    end
  end

  // Register-file writes proceed regardless of stall/flush.
  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        registro_q[i] <= '0;
      end
    end else if (wr_en) begin
      registro_q[DIR_WRA] <= DI;
    end
  end

  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      doa_q   <= '0;
      dob_q   <= '0;
      imm_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      doa_q   <= doa_d;
      dob_q   <= dob_d;
      imm_q   <= imm_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign DOA        = doa_q;
  assign DOB        = dob_q;
  assign out_mux_sz = imm_q;
  assign out_addr   = addr_q;
  assign out_valid  = valid_q;

endmodule
